// File: rtl/rxepktwrite_if.sv
`default_nettype none
// ============================================================================
// rxepktwrite_if : stream-in / packet-RAM-out bundle for the RX packet writer.
// Revision: 1.0
// ============================================================================
interface rxepktwrite_if #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int IW = 4
);
  localparam int LGB = $clog2(DW / 8);

  logic              i_ce;
  logic              i_cancel;
  logic              i_v;
  logic [IW-1:0]     i_d;
  logic              o_wr;
  logic [AW-1:0]     o_addr;
  logic [DW-1:0]     o_data;
  logic [DW/8-1:0]   o_sel;
  logic [AW+LGB:0]   o_len;
  logic              o_done;
  logic              o_overflow;

  modport slv (
    input  i_ce, i_cancel, i_v, i_d,
    output o_wr, o_addr, o_data, o_sel, o_len, o_done, o_overflow
  );

  modport mst (
    output i_ce, i_cancel, i_v, i_d,
    input  o_wr, o_addr, o_data, o_sel, o_len, o_done, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/rxepktwrite.sv
`default_nettype none
// ============================================================================
// rxepktwrite : packs a nibble/byte RX stream MSB-first into DW-bit packet RAM
//               words, reporting byte length, done and overflow.
// Option     : RXEPKTWRITE_FCS_STRIP_EN excludes the 4-byte FCS from o_len.
// Revision   : 1.0
// ============================================================================
module rxepktwrite #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  rxepktwrite_if.slv bus
);
  localparam int NB  = DW / 8;
  localparam int LGB = $clog2(NB);
  localparam int UPW = DW / IW;
  localparam int UB  = $clog2(UPW);
  localparam int UPB = 8 / IW;
  localparam int CW  = AW + UB + 1;
  localparam int LW  = AW + LGB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ucnt_q, ucnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [LW-1:0]   len_q, len_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [CW-1:0]   w_ucur;
  logic [UB-1:0]   w_upos;
  int              w_lane;
  int              w_shift;
  logic [DW-1:0]   w_unit;
  logic [DW-1:0]   w_mask;
  logic [DW-1:0]   w_word;
  logic [NB-1:0]   w_sel;
  logic [LW-1:0]   w_len_raw;
  logic [LW-1:0]   w_len_cap;

  function automatic logic [LW-1:0] f_len(input logic [LW-1:0] raw);
`ifdef RXEPKTWRITE_FCS_STRIP_EN
    f_len = (raw > LW'(4)) ? (raw - LW'(4)) : '0;
`else
    f_len = raw;
`endif
  endfunction

  // The first unit of a packet is always unit 0, whatever ucnt holds in IDLE.
  always_comb begin : p_pack
    w_ucur    = (state_q == ST_IDLE) ? '0 : ucnt_q;
    w_upos    = w_ucur[UB-1:0];
    w_lane    = int'(w_upos) / UPB;
    w_shift   = (NB - 1 - w_lane) * 8 + (((IW == 4) && w_upos[0]) ? 4 : 0);
    w_unit    = {{(DW-IW){1'b0}}, bus.i_d} << w_shift;
    w_mask    = {{(DW-IW){1'b0}}, {IW{1'b1}}} << w_shift;
    w_word    = (w_upos == '0) ? w_unit : ((data_q & ~w_mask) | w_unit);
    w_sel     = NB'(1) << (NB - 1 - w_lane);
    w_len_raw = LW'(({1'b0, ucnt_q} + (CW+1)'(UPB - 1)) >> (UPB - 1));
    w_len_cap = LW'(1) << (AW + LGB);
  end

  always_comb begin : p_fsm
    state_d = state_q;
    ucnt_d  = ucnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    len_d   = len_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.i_ce) begin
      if (bus.i_cancel) begin
        state_d = ST_IDLE;
        ucnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.i_v) begin
              wr_d    = 1'b1;
              addr_d  = '0;
              data_d  = w_word;
              sel_d   = w_sel;
              ucnt_d  = CW'(1);
              ovf_d   = 1'b0;
              state_d = ST_RX;
            end
          end
          ST_RX: begin
            if (!bus.i_v) begin
              done_d  = 1'b1;
              len_d   = f_len(w_len_raw);
              ucnt_d  = '0;
              state_d = ST_IDLE;
            end else if (w_ucur[CW-1]) begin
              // Word address has reached 2^AW: buffer is full.
              ovf_d   = 1'b1;
              state_d = ST_DROP;
            end else begin
              wr_d    = 1'b1;
              addr_d  = w_ucur[CW-2:UB];
              data_d  = w_word;
              sel_d   = w_sel;
              ucnt_d  = ucnt_q + CW'(1);
            end
          end
          ST_DROP: begin
            if (!bus.i_v) begin
              done_d  = 1'b1;
              len_d   = f_len(w_len_cap);
              ucnt_d  = '0;
              state_d = ST_IDLE;
            end
          end
          default: begin
            ucnt_d  = '0;
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ucnt_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ucnt_q  <= ucnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_wr       = wr_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_data     = data_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_len      = len_q;
  assign bus.o_done     = done_q;
  assign bus.o_overflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_rxepktwrite.sv
`default_nettype none
// ============================================================================
// tb_rxepktwrite : scoreboard bench for rxepktwrite (nibble DW=32 AW=4 and
//                  byte DW=64 instances).
// Revision: 1.0
// ============================================================================
module tb_rxepktwrite;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rxepktwrite_if #(.AW(4), .DW(32), .IW(4)) b0();
  rxepktwrite_if #(.AW(6), .DW(64), .IW(8)) b1();

  rxepktwrite #(.AW(4), .DW(32), .IW(4)) u0 (.i_clk(clk), .i_reset(rst), .bus(b0.slv));
  rxepktwrite #(.AW(6), .DW(64), .IW(8)) u1 (.i_clk(clk), .i_reset(rst), .bus(b1.slv));

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  sel;
  } wr_t;
  typedef struct packed {
    logic [15:0] len;
    logic        ovf;
  } dn_t;

  wr_t exp_wr[$];
  wr_t obs_wr0[$];
  wr_t obs_wr1[$];
  dn_t exp_dn[$];
  dn_t obs_dn0[$];
  dn_t obs_dn1[$];

  int checks = 0;
  int errors = 0;
  int mu;
  logic [31:0] mword;

  // Capture every DUT output event; comparisons happen in the test tasks.
  always @(negedge clk) begin
    if (b0.o_wr)   obs_wr0.push_back('{addr: 16'(b0.o_addr), data: 64'(b0.o_data), sel: 8'(b0.o_sel)});
    if (b0.o_done) obs_dn0.push_back('{len: 16'(b0.o_len), ovf: b0.o_overflow});
    if (b1.o_wr)   obs_wr1.push_back('{addr: 16'(b1.o_addr), data: b1.o_data, sel: b1.o_sel});
    if (b1.o_done) obs_dn1.push_back('{len: 16'(b1.o_len), ovf: b1.o_overflow});
  end

  function automatic logic [15:0] exp_len(input int raw);
`ifdef RXEPKTWRITE_FCS_STRIP_EN
    return (raw > 4) ? 16'(raw - 4) : 16'd0;
`else
    return 16'(raw);
`endif
  endfunction

  task automatic step0(input logic ce, input logic cn, input logic v, input logic [3:0] d);
    b0.i_ce = ce; b0.i_cancel = cn; b0.i_v = v; b0.i_d = d;
    @(negedge clk);
  endtask

  task automatic step1(input logic ce, input logic cn, input logic v, input logic [7:0] d);
    b1.i_ce = ce; b1.i_cancel = cn; b1.i_v = v; b1.i_d = d;
    @(negedge clk);
  endtask

  // Reference packing: byte lanes MSB first, even nibble low, odd nibble high.
  task automatic exp_nib(input logic [3:0] d);
    int lane;
    logic [7:0] byt;
    if (mu % 8 == 0) mword = '0;
    lane = (mu % 8) / 2;
    byt = mword[31-8*lane -: 8];
    if (mu % 2 == 0) byt[3:0] = d;
    else             byt[7:4] = d;
    mword[31-8*lane -: 8] = byt;
    exp_wr.push_back('{addr: 16'(mu / 8), data: {32'h0, mword}, sel: 8'h08 >> lane});
    mu++;
  endtask

  task automatic nib(input logic [3:0] d);
    exp_nib(d);
    step0(1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic end_pkt0(input int raw, input logic ovf);
    exp_dn.push_back('{len: exp_len(raw), ovf: ovf});
    mu = 0;
    step0(1'b1, 1'b0, 1'b0, 4'h0);
    step0(1'b0, 1'b0, 1'b0, 4'h0);
    step0(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({b0.o_wr, b0.o_done, b0.o_overflow, b1.o_wr, b1.o_done, b1.o_overflow} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000",
        {b0.o_wr, b0.o_done, b0.o_overflow, b1.o_wr, b1.o_done, b1.o_overflow});
    end
    checks++;
    if ({b0.o_addr, b0.o_data, b0.o_sel, b0.o_len} !== '0) begin
      errors++; $display("FAIL reset_b0_bus got %h/%h/%h/%h want 0", b0.o_addr, b0.o_data, b0.o_sel, b0.o_len);
    end
    checks++;
    if ({b1.o_addr, b1.o_data, b1.o_sel, b1.o_len} !== '0) begin
      errors++; $display("FAIL reset_b1_bus got %h/%h/%h/%h want 0", b1.o_addr, b1.o_data, b1.o_sel, b1.o_len);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    mu = 0;
    for (int i = 1; i <= 4; i++) nib(4'(i));
    end_pkt0(2, 1'b0);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr0.size() == 0) begin errors++; $display("FAIL basic_wr got none want %h", e); end
      else if (obs_wr0[0] !== e) begin errors++; $display("FAIL basic_wr got %h want %h", obs_wr0.pop_front(), e); end
      else void'(obs_wr0.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn0.size() == 0) begin errors++; $display("FAIL basic_done got none want %h", e); end
      else if (obs_dn0[0] !== e) begin errors++; $display("FAIL basic_done got %h want %h", obs_dn0.pop_front(), e); end
      else void'(obs_dn0.pop_front());
    end
    checks++;
    if (obs_wr0.size() + obs_dn0.size() != 0) begin
      errors++; $display("FAIL basic_extra got %0d events want 0", obs_wr0.size() + obs_dn0.size());
      obs_wr0.delete(); obs_dn0.delete();
    end
  endtask

  task automatic test_rollover;
    mu = 0;
    for (int i = 1; i <= 9; i++) nib(4'(i));
    end_pkt0(5, 1'b0);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr0.size() == 0) begin errors++; $display("FAIL roll_wr got none want %h", e); end
      else if (obs_wr0[0] !== e) begin errors++; $display("FAIL roll_wr got %h want %h", obs_wr0.pop_front(), e); end
      else void'(obs_wr0.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn0.size() == 0) begin errors++; $display("FAIL roll_done got none want %h", e); end
      else if (obs_dn0[0] !== e) begin errors++; $display("FAIL roll_done got %h want %h", obs_dn0.pop_front(), e); end
      else void'(obs_dn0.pop_front());
    end
    checks++;
    if (obs_wr0.size() + obs_dn0.size() != 0) begin
      errors++; $display("FAIL roll_extra got %0d events want 0", obs_wr0.size() + obs_dn0.size());
      obs_wr0.delete(); obs_dn0.delete();
    end
  endtask

  task automatic test_cancel;
    mu = 0;
    for (int i = 1; i <= 6; i++) nib(4'(i));
    step0(1'b1, 1'b1, 1'b1, 4'h7);
    step0(1'b1, 1'b0, 1'b0, 4'h0);
    mu = 0;
    nib(4'h5);
    end_pkt0(1, 1'b0);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr0.size() == 0) begin errors++; $display("FAIL cancel_wr got none want %h", e); end
      else if (obs_wr0[0] !== e) begin errors++; $display("FAIL cancel_wr got %h want %h", obs_wr0.pop_front(), e); end
      else void'(obs_wr0.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn0.size() == 0) begin errors++; $display("FAIL cancel_done got none want %h", e); end
      else if (obs_dn0[0] !== e) begin errors++; $display("FAIL cancel_done got %h want %h", obs_dn0.pop_front(), e); end
      else void'(obs_dn0.pop_front());
    end
    checks++;
    if (obs_wr0.size() + obs_dn0.size() != 0) begin
      errors++; $display("FAIL cancel_extra got %0d events want 0", obs_wr0.size() + obs_dn0.size());
      obs_wr0.delete(); obs_dn0.delete();
    end
  endtask

  task automatic test_overflow;
    mu = 0;
    for (int k = 0; k < 128; k++) nib(4'(k));
    step0(1'b1, 1'b0, 1'b1, 4'hE);
    step0(1'b1, 1'b0, 1'b1, 4'hF);
    end_pkt0(64, 1'b1);
    nib(4'h3);
    checks++;
    if (b0.o_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", b0.o_overflow);
    end
    end_pkt0(1, 1'b0);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr0.size() == 0) begin errors++; $display("FAIL ovf_wr got none want %h", e); end
      else if (obs_wr0[0] !== e) begin errors++; $display("FAIL ovf_wr got %h want %h", obs_wr0.pop_front(), e); end
      else void'(obs_wr0.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn0.size() == 0) begin errors++; $display("FAIL ovf_done got none want %h", e); end
      else if (obs_dn0[0] !== e) begin errors++; $display("FAIL ovf_done got %h want %h", obs_dn0.pop_front(), e); end
      else void'(obs_dn0.pop_front());
    end
    checks++;
    if (obs_wr0.size() + obs_dn0.size() != 0) begin
      errors++; $display("FAIL ovf_extra got %0d events want 0", obs_wr0.size() + obs_dn0.size());
      obs_wr0.delete(); obs_dn0.delete();
    end
  endtask

  task automatic test_ce_third;
    mu = 0;
    for (int i = 1; i <= 4; i++) begin
      nib(4'(i));
      for (int j = 0; j < 2; j++) begin
        step0(1'b0, 1'b0, 1'b1, 4'hF);
        checks++;
        if (b0.o_wr !== 1'b0 || b0.o_data !== mword || b0.o_addr !== 4'd0) begin
          errors++; $display("FAIL third_hold got wr=%b data=%h addr=%h want wr=0 data=%h addr=0",
            b0.o_wr, b0.o_data, b0.o_addr, mword);
        end
      end
    end
    end_pkt0(2, 1'b0);
    checks++;
    if (b0.o_len !== 7'(exp_len(2)) || b0.o_done !== 1'b0) begin
      errors++; $display("FAIL third_len_hold got len=%0d done=%b want len=%0d done=0", b0.o_len, b0.o_done, exp_len(2));
    end
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr0.size() == 0) begin errors++; $display("FAIL third_wr got none want %h", e); end
      else if (obs_wr0[0] !== e) begin errors++; $display("FAIL third_wr got %h want %h", obs_wr0.pop_front(), e); end
      else void'(obs_wr0.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn0.size() == 0) begin errors++; $display("FAIL third_done got none want %h", e); end
      else if (obs_dn0[0] !== e) begin errors++; $display("FAIL third_done got %h want %h", obs_dn0.pop_front(), e); end
      else void'(obs_dn0.pop_front());
    end
    checks++;
    if (obs_wr0.size() + obs_dn0.size() != 0) begin
      errors++; $display("FAIL third_extra got %0d events want 0", obs_wr0.size() + obs_dn0.size());
      obs_wr0.delete(); obs_dn0.delete();
    end
  endtask

  task automatic test_reset_mid;
    mu = 0;
    nib(4'h1); nib(4'h2); nib(4'h3);
    b0.i_ce = 1'b0; b0.i_v = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({b0.o_wr, b0.o_done, b0.o_overflow, b0.o_addr, b0.o_data, b0.o_sel} !== '0) begin
      errors++; $display("FAIL midreset_async got data=%h sel=%b want 0", b0.o_data, b0.o_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mu = 0;
    nib(4'h6);
    end_pkt0(1, 1'b0);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr0.size() == 0) begin errors++; $display("FAIL midreset_wr got none want %h", e); end
      else if (obs_wr0[0] !== e) begin errors++; $display("FAIL midreset_wr got %h want %h", obs_wr0.pop_front(), e); end
      else void'(obs_wr0.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn0.size() == 0) begin errors++; $display("FAIL midreset_done got none want %h", e); end
      else if (obs_dn0[0] !== e) begin errors++; $display("FAIL midreset_done got %h want %h", obs_dn0.pop_front(), e); end
      else void'(obs_dn0.pop_front());
    end
    checks++;
    if (obs_wr0.size() + obs_dn0.size() != 0) begin
      errors++; $display("FAIL midreset_extra got %0d events want 0", obs_wr0.size() + obs_dn0.size());
      obs_wr0.delete(); obs_dn0.delete();
    end
  endtask

  task automatic test_byte;
    exp_wr.push_back('{addr: 16'd0, data: 64'hAA00_0000_0000_0000, sel: 8'h80});
    exp_wr.push_back('{addr: 16'd0, data: 64'hAABB_0000_0000_0000, sel: 8'h40});
    exp_dn.push_back('{len: exp_len(2), ovf: 1'b0});
    step1(1'b1, 1'b0, 1'b1, 8'hAA);
    step1(1'b1, 1'b0, 1'b1, 8'hBB);
    step1(1'b1, 1'b0, 1'b0, 8'h00);
    step1(1'b0, 1'b0, 1'b0, 8'h00);
    step1(1'b0, 1'b0, 1'b0, 8'h00);
    while (exp_wr.size() > 0) begin
      wr_t e;
      e = exp_wr.pop_front(); checks++;
      if (obs_wr1.size() == 0) begin errors++; $display("FAIL byte_wr got none want %h", e); end
      else if (obs_wr1[0] !== e) begin errors++; $display("FAIL byte_wr got %h want %h", obs_wr1.pop_front(), e); end
      else void'(obs_wr1.pop_front());
    end
    while (exp_dn.size() > 0) begin
      dn_t e;
      e = exp_dn.pop_front(); checks++;
      if (obs_dn1.size() == 0) begin errors++; $display("FAIL byte_done got none want %h", e); end
      else if (obs_dn1[0] !== e) begin errors++; $display("FAIL byte_done got %h want %h", obs_dn1.pop_front(), e); end
      else void'(obs_dn1.pop_front());
    end
    checks++;
    if (obs_wr1.size() + obs_dn1.size() != 0) begin
      errors++; $display("FAIL byte_extra got %0d events want 0", obs_wr1.size() + obs_dn1.size());
      obs_wr1.delete(); obs_dn1.delete();
    end
  endtask

  initial begin
    b0.i_ce = 1'b0; b0.i_cancel = 1'b0; b0.i_v = 1'b0; b0.i_d = '0;
    b1.i_ce = 1'b0; b1.i_cancel = 1'b0; b1.i_v = 1'b0; b1.i_d = '0;
    mu = 0;
    mword = '0;
    test_reset();
    test_basic();
    test_rollover();
    test_cancel();
    test_overflow();
    test_ce_third();
    test_reset_mid();
    test_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rxepktwrite.md
# rxepktwrite

Parametrised receive-path packet writer for the Ethernet RX chain. It consumes a filtered stream of nibbles or bytes, packs them first-byte-in-MSB into DW-bit memory words, and issues per-unit write strobes with byte-lane selects to packet RAM. It reports packet byte length with a done pulse, detects buffer overflow, and sits between the last RX filter stage and the RX packet buffer.

## Interface
- AW, 12: packet buffer address width, in words; capacity is 2^AW words.
- DW, 32: memory word width, 32 or 64; LGB = log2(DW/8).
- IW, 4: input unit width, 4 (nibble) or 8 (byte).
- i_clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_ce  in  1  input strobe; all state advances only on i_ce.
- i_cancel  in  1  abort current packet.
- i_v  in  1  input unit valid.
- i_d  in  IW  input unit.
- o_wr  out  1  write strobe, one clock wide.
- o_addr  out  AW  word address.
- o_data  out  DW  accumulated word contents.
- o_sel  out  DW/8  one-hot byte lane written this strobe.
- o_len  out  AW+LGB+1  packet length in bytes.
- o_done  out  1  end-of-packet pulse, one clock wide.
- o_overflow  out  1  packet exceeded capacity; valid with o_done.

## Operation
- States: IDLE, RX, DROP. Unit counter ucnt has width AW+log2(DW/IW)+1.
- IDLE, i_ce and i_v: store unit 0 and go to RX.
- RX, i_ce and i_v: store the unit at ucnt.
- Word address = ucnt / (DW/IW). Byte lane = (ucnt mod (DW/IW)) / (8/IW). Lane 0 is the MSB byte.
- Nibble mode: the even unit fills the low nibble of its byte; the odd unit fills the high nibble.
- On the first unit of each word, o_data is cleared to zero apart from the new unit. Later units in the word preserve earlier units.
- RX, i_ce and !i_v: o_done=1, latch o_len = ceil(ucnt*IW/8), go to IDLE, clear ucnt.
- RX, unit would land at word address 2^AW: suppress o_wr, set o_overflow, go to DROP.
- DROP, i_ce and i_v: no writes.
- DROP, i_ce and !i_v: o_done=1, o_len = capacity bytes (2^AW·DW/8), go to IDLE.
- i_cancel with i_ce, from any state: go to IDLE, clear ucnt, no o_done, no o_wr. i_cancel has priority over i_v in the same cycle.
- o_overflow clears on the first unit of the next packet.
- o_len holds from o_done until the next o_done.
- i_ce low: state, ucnt, o_addr, o_data, o_len and o_overflow hold; o_wr=0, o_done=0.

## Timing
- Reset values: o_wr=0, o_addr=0, o_data=0, o_sel=0, o_len=0, o_done=0, o_overflow=0, state IDLE, ucnt=0.
- Latency: one clock from the i_ce sample to o_wr, o_addr, o_data, o_sel.
- o_done and o_overflow are registered; they appear one clock after the terminating i_ce sample.
- Back-to-back packets: a single i_ce with !i_v between packets is sufficient. The next unit starts at address 0.
- Reset asserted mid-packet: outputs go to reset values immediately, with no o_done. The first packet after release starts at address 0.

## Configuration
- RXEPKTWRITE_FCS_STRIP_EN defined: o_len on each packet is the byte count minus 4, saturating at 0, so the trailing FCS is excluded. Writes are unaffected; FCS bytes are still stored.
- RXEPKTWRITE_FCS_STRIP_EN undefined: o_len is the raw byte count.

## Test plan
- Basic nibble packing (DW=32, IW=4, i_ce every clock): nibbles 1,2,3,4, then !i_v.
  - Writes at addr 0: 0x01000000 sel 1000, 0x21000000 sel 1000, 0x21030000 sel 0100, 0x21430000 sel 0100.
  - Then o_done=1, o_len=2.
- Word rollover: 9 nibbles 1..9 then !i_v. Ninth write is addr 1, data 0x09000000, sel 1000; o_len=5.
- Cancel mid-packet: 6 nibbles, then i_cancel=1 with i_v=1. Required: no o_done, no further o_wr. The next packet's first write is addr 0.
- Overflow (AW=4): 130 nibbles then !i_v. Required: exactly 128 o_wr pulses, the last at addr 15; then o_done=1, o_overflow=1, o_len=64.
- i_ce every third clock: same write sequence as the basic nibble-packing case. Each o_wr is one clock wide. Outputs hold between strobes.
- Byte mode (IW=8, DW=64): bytes 0xAA,0xBB then !i_v. Writes 0xAA00000000000000 sel 0x80, then 0xAABB000000000000 sel 0x40; o_len=2, or 0 with RXEPKTWRITE_FCS_STRIP_EN.
